video_row_fetcher: RTL
======================

# video_row_fetcher

Reads character cells back out of SDRAM for display, one text row at a time, into a ping-pong line buffer that the video pipeline indexes by column. It is the read-side counterpart of the terminal stream writer. Both share the same cell layout: one 32-bit cell per column, with byte address {row, column, 2'b00}. It also applies the same scroll register (VIDEO_SET_FIRST_ROW), so logical row 0 maps to physical row first_row. It sits between the SDRAM read port and the character generator.

## Interface
- COLUMNS, 80: cells per text row; also the burst length (max 128).
- ROWS, 51: text rows per page; physical rows wrap modulo ROWS.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- register_index  in  4  video register select; only VIDEO_SET_FIRST_ROW is decoded, all other codes (VIDEO_NOP included) are ignored.
- register_value  in  23  register payload; first row is in bits [14:9].
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- row_start  in  1  one-cycle pulse when display begins a new text row.
- rd_address  out  23  SDRAM byte address of the burst.
- rd_request  out  1  one-cycle burst request pulse.
- rd_burst_length  out  9  constant COLUMNS.
- rd_data  in  32  returned cell.
- rd_data_valid  in  1  qualifies rd_data; exactly COLUMNS beats per request, in order.
- lb_column  in  7  column read by video.
- lb_cell  out  32  cell at lb_column from the front bank; registered.
- underrun  out  1  sticky; set when a row is shown before its fetch completed.
- busy  out  1  high while a fetch is in progress.

## Operation
- Register capture: when register_index == VIDEO_SET_FIRST_ROW, store register_value[14:9] in pending_first_row. Values >= ROWS are stored as 0.
- frame_start actions:
  - copy pending_first_row into active_first_row;
  - set fetch_row = 0;
  - clear display_row;
  - start fetching logical row 0 into the back bank.
- row_start actions:
  - swap front/back banks;
  - display_row increments;
  - fetch_row = display_row + 1, if that is < ROWS; otherwise no fetch is issued.
- Physical row = fetch_row + active_first_row. If the sum is >= ROWS, subtract ROWS. The add is 7 bits wide, the result 6 bits.
- rd_address = {8'b0, phys_row, 7'b0, 2'b00}, i.e. phys_row × 512.
- States:
  - IDLE: a fetch trigger moves to REQUEST.
  - REQUEST: issue the rd_request pulse and the address for one cycle, clear beat_count, move to RECEIVE.
  - RECEIVE: each rd_data_valid writes the back bank at beat_count, then beat_count increments. At beat_count == COLUMNS-1 with valid, move to IDLE.
- Underrun: if row_start arrives in REQUEST or RECEIVE, set underrun and swap anyway.
  - The current fetch is abandoned: return to IDLE, then REQUEST for the new row next cycle.
  - Remaining beats of the abandoned burst are discarded via a drop counter before new beats are accepted.
- frame_start during a fetch: same abandon/drop behaviour, without setting underrun.
- Simultaneous frame_start and row_start: frame_start wins, row_start is ignored.
- Line buffer: 2 × COLUMNS × 32. The back bank is written only by the fetch; the front bank is read only by video.

## Timing
- Reset values:
  - rd_address = 0, rd_request = 0, rd_burst_length = COLUMNS;
  - lb_cell = 0, underrun = 0, busy = 0;
  - pending/active first row = 0, front bank = 0, state = IDLE.
- rd_request rises the cycle after the trigger (frame_start, row_start, or IDLE after abandon).
- busy is high from REQUEST through the last RECEIVE cycle.
- lb_cell is valid 1 cycle after lb_column.
- A bank swap takes effect for lb_cell reads issued the cycle after row_start.
- A register write at frame_start in the same cycle is not applied until the next frame_start.
- Reset mid-burst aborts immediately. Any late rd_data_valid beats after reset deasserts are ignored until the next rd_request.

## Structure
- Shared package/include (video_controller/registers.v, constant.v): VIDEO_SET_FIRST_ROW, VIDEO_NOP, ROWS, COLUMNS, ROW_SIZE = 512, state encodings.
- One sub-module: line_buffer_pingpong.
  - Dual-port RAM, 2 × COLUMNS words.
  - Write port: bank select + index.
  - Registered read port.

## Test plan
- Reset, frame_start with first_row 0 → rd_address 0x0000, burst 80; row_start → rd_address 0x0200; lb_cell[5] equals the 6th beat of the first burst.
- Write VIDEO_SET_FIRST_ROW value {6'd50, 9'd0}, then frame_start → row 0 fetch at 50×512 = 0x6400; next row wraps to address 0.
- Register write mid-frame → addresses unchanged until the next frame_start.
- row_start after 40 of 80 beats → underrun = 1. The remaining 40 beats are dropped; the next burst's beats land at index 0.
- row_start for display_row 50 (ROWS-1) → no rd_request issued.
- frame_start and row_start in the same cycle → fetch of logical row 0 only, no bank swap, underrun unchanged.

Source files
------------

// File: rtl/video_row_fetcher_pkg.sv
// Shared constants, register codes and row/address helpers for the text-row fetcher.
package video_row_fetcher_pkg;

    localparam int COLUMNS  = 80;
    localparam int ROWS     = 51;
    localparam int ROW_SIZE = 512;

    localparam logic [3:0] VIDEO_NOP           = 4'h0;
    localparam logic [3:0] VIDEO_SET_FIRST_ROW = 4'h3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RECEIVE = 2'd2
    } fetch_state_t;

    // Scroll mapping: logical row plus first row, folded back into 0..ROWS-1.
    function automatic logic [5:0] phys_row(input logic [5:0] logical_row,
                                            input logic [5:0] first_row);
        logic [6:0] sum;
        sum = {1'b0, logical_row} + {1'b0, first_row};
        if (sum >= 7'(ROWS)) begin
            sum = sum - 7'(ROWS);
        end
        return sum[5:0];
    endfunction

    function automatic logic [22:0] row_address(input logic [5:0] row);
        return {8'b0, row, 7'b0, 2'b00};
    endfunction

endpackage

// File: rtl/video_row_fetcher_if.sv
// SDRAM burst read port between the row fetcher (master) and the memory controller (slave).
interface video_row_fetcher_if;

    logic [22:0] address;
    logic        request;
    logic [8:0]  burst_length;
    logic [31:0] data;
    logic        data_valid;

    modport master (
        output address,
        output request,
        output burst_length,
        input  data,
        input  data_valid
    );

    modport slave (
        input  address,
        input  request,
        input  burst_length,
        output data,
        output data_valid
    );

endinterface

// File: rtl/video_row_fetcher_line_buffer_pingpong.sv
// Two-bank line buffer: one bank filled by the fetcher, the other read by video.
module line_buffer_pingpong
    import video_row_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_enable,
    input  logic        wr_bank,
    input  logic [6:0]  wr_index,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_index,
    output logic [31:0] rd_data
);

    localparam int DEPTH = 2 * COLUMNS;
    localparam int AW    = $clog2(DEPTH);

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rd_data_reg;

    function automatic logic [AW-1:0] word_addr(input logic bank, input logic [6:0] index);
        return (bank ? AW'(COLUMNS) : AW'(0)) + AW'(index);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_enable) begin
            mem[word_addr(wr_bank, wr_index)] <= wr_data;
        end
    end

    // Columns past the row end hold the previous output instead of reading off the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_index < 7'(COLUMNS)) begin
            rd_data_reg <= mem[word_addr(rd_bank, rd_index)];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/video_row_fetcher.sv
// Fetches one scrolled text row per display row from SDRAM into the back bank of a
// ping-pong line buffer; video reads the front bank by column.
module video_row_fetcher
    import video_row_fetcher_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            register_index,
    input  logic [22:0]           register_value,
    input  logic                  frame_start,
    input  logic                  row_start,
    video_row_fetcher_if.master   rd,
    input  logic [6:0]            lb_column,
    output logic [31:0]           lb_cell,
    output logic                  underrun,
    output logic                  busy
);

    fetch_state_t state_reg, state_next;
    logic [6:0]  beat_count_reg, beat_count_next;
    logic [9:0]  drop_count_reg, drop_count_next;
    logic        fetch_pending_reg, fetch_pending_next;
    logic [5:0]  pending_first_row_reg, active_first_row_reg;
    logic [5:0]  display_row_reg;
    logic        front_bank_reg;
    logic        underrun_reg;
    logic [22:0] address_reg;

    logic        row_event;
    logic [6:0]  next_display_row;
    logic        fetch_trigger;
    logic [5:0]  fetch_row;
    logic [5:0]  first_row_sel;
    logic [5:0]  first_row_field;
    logic        abandon;
    logic        drop_beat;
    logic        accept_beat;
    logic        write_enable;
    logic [9:0]  outstanding;
    logic        register_value_unused;

    assign register_value_unused = &{1'b0, register_value[22:15], register_value[8:0]};
    assign first_row_field = register_value[14:9];

    // frame_start overrides a coincident row_start entirely.
    assign row_event        = row_start & ~frame_start;
    assign next_display_row = {1'b0, display_row_reg} + 7'd1;
    assign fetch_trigger    = frame_start | (row_event & (next_display_row < 7'(ROWS)));
    assign fetch_row        = frame_start ? 6'd0 : next_display_row[5:0];
    assign first_row_sel    = frame_start ? pending_first_row_reg : active_first_row_reg;
    assign abandon          = (frame_start | row_start) & (state_reg != IDLE);

    // Beats still owed by an abandoned burst are swallowed before any new beat is accepted.
    assign drop_beat   = rd.data_valid & (drop_count_reg != 10'd0);
    assign accept_beat = rd.data_valid & (drop_count_reg == 10'd0) & (state_reg == RECEIVE);

    always_comb begin
        outstanding = 10'(COLUMNS);
        if (state_reg == RECEIVE) begin
            outstanding = 10'(COLUMNS) - 10'(beat_count_reg) - 10'(accept_beat);
        end
    end

    always_comb begin
        state_next         = state_reg;
        beat_count_next    = beat_count_reg;
        fetch_pending_next = fetch_pending_reg;
        drop_count_next    = drop_count_reg - 10'(drop_beat);
        write_enable       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fetch_trigger || (fetch_pending_reg && !row_event)) begin
                    state_next = REQUEST;
                end
                fetch_pending_next = 1'b0;
            end
            REQUEST: begin
                beat_count_next = '0;
                state_next      = RECEIVE;
            end
            RECEIVE: begin
                if (accept_beat) begin
                    write_enable    = 1'b1;
                    beat_count_next = beat_count_reg + 7'd1;
                    if (beat_count_reg == 7'(COLUMNS - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abandon) begin
            state_next         = IDLE;
            fetch_pending_next = fetch_trigger;
            write_enable       = 1'b0;
            drop_count_next    = drop_count_next + outstanding;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg             <= IDLE;
            beat_count_reg        <= '0;
            drop_count_reg        <= '0;
            fetch_pending_reg     <= 1'b0;
            pending_first_row_reg <= '0;
            active_first_row_reg  <= '0;
            display_row_reg       <= '0;
            front_bank_reg        <= 1'b0;
            underrun_reg          <= 1'b0;
            address_reg           <= '0;
        end else begin
            state_reg         <= state_next;
            beat_count_reg    <= beat_count_next;
            drop_count_reg    <= drop_count_next;
            fetch_pending_reg <= fetch_pending_next;

            if (register_index == VIDEO_SET_FIRST_ROW) begin
                pending_first_row_reg <= (first_row_field >= 6'(ROWS)) ? 6'd0 : first_row_field;
            end

            if (frame_start) begin
                active_first_row_reg <= pending_first_row_reg;
                display_row_reg      <= '0;
            end else if (row_start) begin
                front_bank_reg <= ~front_bank_reg;
                if (display_row_reg != 6'(ROWS)) begin
                    display_row_reg <= display_row_reg + 6'd1;
                end
                if (state_reg != IDLE) begin
                    underrun_reg <= 1'b1;
                end
            end

            if (fetch_trigger) begin
                address_reg <= row_address(phys_row(fetch_row, first_row_sel));
            end
        end
    end

    line_buffer_pingpong u_line_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_enable (write_enable),
        .wr_bank   (~front_bank_reg),
        .wr_index  (beat_count_reg),
        .wr_data   (rd.data),
        .rd_bank   (front_bank_reg),
        .rd_index  (lb_column),
        .rd_data   (lb_cell)
    );

    assign rd.address      = address_reg;
    assign rd.request      = (state_reg == REQUEST);
    assign rd.burst_length = 9'(COLUMNS);
    assign underrun        = underrun_reg;
    assign busy            = (state_reg != IDLE);

endmodule
